// File: rtl/note_seq_ctrl.sv
// -----------------------------------------------------------------------------
// note_seq_ctrl
//   Keyboard-piano note scheduler. ASCII note letters arrive over a valid/ready
//   stream and are mapped to note indices:
//     c d e f g a b -> 0..6
//     C D E F G A B -> 7..13
//   Any other code completes the handshake but is dropped.
//   Accepted notes are queued in a small FIFO. Each one sounds for
//   NOTE_TICKS*TICK_DIV cycles and is followed by a silent gap of
//   GAP_TICKS*TICK_DIV cycles. When GAP_TICKS is 0 there is no gap state, and
//   queued notes follow each other with no silent cycle between them.
//
//   Optional feature macro: NOTE_SEQ_REPEAT_EN
//     When it is defined, the block has a repeat_en input. While repeat_en is
//     1, every popped note is pushed back onto the FIFO tail, so the melody
//     loops, and external input is blocked (in_ready = 0).
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   rst_n     in   asynchronous reset, active low
//   in_valid  in   an ASCII letter is present on in_ascii
//   in_ascii  in   [7:0] ASCII letter
//   in_ready  out  letter accepted on an edge where in_valid && in_ready
//   stop      in   pulse: flush the queue and abort the current note
//   repeat_en in   loop playback (only with NOTE_SEQ_REPEAT_EN)
//   note      out  [3:0] index of the current or last played note
//   tone_on   out  1 while a note sounds
//   busy      out  state is PLAY or GAP, or the FIFO is non-empty
//   q_level   out  FIFO occupancy
// -----------------------------------------------------------------------------
module note_seq_ctrl #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned TICK_DIV   = 100000,
   parameter int unsigned NOTE_TICKS = 250,
   parameter int unsigned GAP_TICKS  = 50
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [7:0]               in_ascii,
   output logic                     in_ready,
   input  logic                     stop,
`ifdef NOTE_SEQ_REPEAT_EN
   input  logic                     repeat_en,
`endif
   output logic [3:0]               note,
   output logic                     tone_on,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   q_level
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned LW       = AW + 1;
   localparam int unsigned NOTE_CYC = NOTE_TICKS * TICK_DIV;
   localparam int unsigned GAP_CYC  = GAP_TICKS * TICK_DIV;
   localparam int unsigned MAX_CYC  = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
   localparam int unsigned CW       = $clog2(MAX_CYC + 1);
   localparam bit          HAS_GAP  = (GAP_CYC > 0);

   // The counter holds "cycles left after this one", so it loads with N-1 and
   // the state ends on the edge where the counter reads 0.
   localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD  = HAS_GAP ? CW'(GAP_CYC - 1) : '0;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CW-1:0]   dur_q,   dur_d;
   logic [3:0]      note_q,  note_d;
   logic            tone_q,  tone_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]   cnt_q,   cnt_d;
   logic [3:0]      mem_q [DEPTH];

   // ---------------------------------------------------------------------------
   // Configuration-dependent repeat control
   // ---------------------------------------------------------------------------
   logic repeat_on;
`ifdef NOTE_SEQ_REPEAT_EN
   assign repeat_on = repeat_en;
`else
   assign repeat_on = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // ASCII letter to note index
   // ---------------------------------------------------------------------------
   logic       code_ok;
   logic [3:0] code_idx;

   always_comb begin
      code_ok  = 1'b1;
      code_idx = 4'd0;
      unique case (in_ascii)
         8'd99:   code_idx = 4'd0;   // c
         8'd100:  code_idx = 4'd1;   // d
         8'd101:  code_idx = 4'd2;   // e
         8'd102:  code_idx = 4'd3;   // f
         8'd103:  code_idx = 4'd4;   // g
         8'd97:   code_idx = 4'd5;   // a
         8'd98:   code_idx = 4'd6;   // b
         8'd67:   code_idx = 4'd7;   // C
         8'd68:   code_idx = 4'd8;   // D
         8'd69:   code_idx = 4'd9;   // E
         8'd70:   code_idx = 4'd10;  // F
         8'd71:   code_idx = 4'd11;  // G
         8'd65:   code_idx = 4'd12;  // A
         8'd66:   code_idx = 4'd13;  // B
         default: code_ok  = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO status and handshake
   // ---------------------------------------------------------------------------
   logic       full, empty;
   logic [3:0] head;
   logic       ext_push, rep_push, push, pop;
   logic [3:0] push_data;

   assign full  = (cnt_q == FULL_LVL);
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Ready is taken from the registered level only. A pop on the same edge
   // does not open a slot for the incoming letter.
   assign in_ready = !full && !repeat_on;

   // Unknown codes complete the handshake but are never written.
   assign ext_push = in_valid && in_ready && code_ok;

   // A looped note goes back onto the tail on the same edge it is popped.
   // External pushes are blocked while repeat is on, so the two never collide.
   assign rep_push  = pop && repeat_on;
   assign push      = ext_push || rep_push;
   assign push_data = rep_push ? head : code_idx;

   // ---------------------------------------------------------------------------
   // Sequencer next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      dur_d   = dur_q;
      note_d  = note_q;
      tone_d  = tone_q;
      pop     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               note_d  = head;
               tone_d  = 1'b1;
               dur_d   = NOTE_LOAD;
               state_d = S_PLAY;
            end
         end

         S_PLAY: begin
            if (dur_q != '0) begin
               dur_d = dur_q - 1'b1;
            end else if (HAS_GAP) begin
               tone_d  = 1'b0;
               dur_d   = GAP_LOAD;
               state_d = S_GAP;
            end else if (!empty) begin
               // No gap configured: the next note starts with tone_on still high.
               pop    = 1'b1;
               note_d = head;
               dur_d  = NOTE_LOAD;
            end else begin
               tone_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         S_GAP: begin
            if (dur_q != '0) begin
               dur_d = dur_q - 1'b1;
            end else if (!empty) begin
               pop     = 1'b1;
               note_d  = head;
               tone_d  = 1'b1;
               dur_d   = NOTE_LOAD;
               state_d = S_PLAY;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            tone_d  = 1'b0;
            dur_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Stop overrides everything. The note output keeps its last value.
      if (stop) begin
         pop     = 1'b0;
         tone_d  = 1'b0;
         dur_d   = '0;
         state_d = S_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO pointer and level next state
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;

      if (stop) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         // DEPTH is a power of 2, so the pointers wrap by plain overflow.
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         dur_q    <= '0;
         note_q   <= 4'd0;
         tone_q   <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         dur_q    <= dur_d;
         note_q   <= note_d;
         tone_q   <= tone_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // When the FIFO is full and repeat is on, the write slot is the slot being
   // read, and the same value is written back into it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
      end else if (push && !stop) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign note    = note_q;
   assign tone_on = tone_q;
   assign q_level = cnt_q;
   assign busy    = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_note_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_note_seq_ctrl
//   Directed bench for note_seq_ctrl.
//   Configuration: TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1, DEPTH=4.
//   This gives NOTE_CYC=8 and GAP_CYC=4.
//   Inputs are driven 1 time unit after the rising edge, and outputs are
//   sampled at the same point.
// -----------------------------------------------------------------------------
module tb_note_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_ascii = 8'd0;
   logic       in_ready;
   logic       stop = 1'b0;
`ifdef NOTE_SEQ_REPEAT_EN
   logic       repeat_en = 1'b0;
`endif
   logic [3:0] note;
   logic       tone_on;
   logic       busy;
   logic [2:0] q_level;

   int checks = 0;
   int errors = 0;

   // Notes in the order they began sounding (rising edge of tone_on).
   int   played[$];
   logic tone_prev = 1'b0;

   note_seq_ctrl #(
      .DEPTH(4), .TICK_DIV(4), .NOTE_TICKS(2), .GAP_TICKS(1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ascii (in_ascii),
      .in_ready (in_ready),
      .stop     (stop),
`ifdef NOTE_SEQ_REPEAT_EN
      .repeat_en(repeat_en),
`endif
      .note     (note),
      .tone_on  (tone_on),
      .busy     (busy),
      .q_level  (q_level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tone_on && !tone_prev) played.push_back(int'(note));
      tone_prev <= tone_on;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      if (tone_on !== 1'b0 || q_level !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0 || note !== 4'd0) begin
         errors++;
         $display("FAIL reset_state tone_on=%b q_level=%0d in_ready=%b busy=%b note=%0d want 0 0 1 0 0",
                  tone_on, q_level, in_ready, busy, note);
      end
      checks++;
      #3 rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_ascii = "g";
      tick();
      in_valid = 1'b0;
      tick(); tick();
      if (tone_on !== 1'b1 || note !== 4'd4) begin
         errors++;
         $display("FAIL reset_preplay tone_on=%b note=%0d want 1 4", tone_on, note);
      end
      checks++;
      // Assert reset between edges. The outputs must clear with no clock edge.
      #2 rst_n = 1'b0;
      #1;
      if (tone_on !== 1'b0 || q_level !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_async tone_on=%b q_level=%0d in_ready=%b busy=%b want 0 0 1 0",
                  tone_on, q_level, in_ready, busy);
      end
      checks++;
      #1 rst_n = 1'b1;
      tick(); tick();
      if (tone_on !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_after tone_on=%b busy=%b want 0 0", tone_on, busy);
      end
      checks++;
   endtask

   task automatic test_single();
      logic exp_tone, exp_busy;
      played.delete();
      in_valid = 1'b1; in_ascii = "e";
      tick();                                // edge k
      in_valid = 1'b0;
      if (q_level !== 3'd1 || tone_on !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_accept q_level=%0d tone_on=%b busy=%b want 1 0 1", q_level, tone_on, busy);
      end
      checks++;
      // After edge k+i, the level reflects what edge k+i+1 samples.
      for (int i = 1; i <= 13; i++) begin
         tick();
         exp_tone = (i <= 8);
         exp_busy = (i <= 12);
         if (tone_on !== exp_tone || busy !== exp_busy || note !== 4'd2) begin
            errors++;
            $display("FAIL single_cyc%0d tone_on=%b busy=%b note=%0d want %b %b 2",
                     i, tone_on, busy, note, exp_tone, exp_busy);
         end
         checks++;
      end
   endtask

   task automatic test_mapping();
      string s = "cgaCGAB";
      int    exp_idx[7] = '{0, 4, 5, 7, 11, 12, 13};
      logic [7:0] bad[2];
      bad[0] = "z"; bad[1] = "H";
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_ascii = s[i];
         tick();
         in_valid = 1'b0;
         tick();
         if (tone_on !== 1'b1 || note !== exp_idx[i][3:0]) begin
            errors++;
            $display("FAIL map_%s tone_on=%b note=%0d want 1 %0d", s.substr(i, i), tone_on, note, exp_idx[i]);
         end
         checks++;
         for (int j = 0; j < 12; j++) tick();
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL map_idle_%0d busy=%b want 0", i, busy);
         end
         checks++;
      end
      played.delete();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_ascii = bad[i];
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL map_bad_ready%0d in_ready=%b want 1", i, in_ready);
         end
         checks++;
         tick();
         in_valid = 1'b0;
         if (q_level !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL map_bad_level%0d q_level=%0d busy=%b want 0 0", i, q_level, busy);
         end
         checks++;
      end
      tick(); tick(); tick();
      if (tone_on !== 1'b0 || played.size() != 0) begin
         errors++;
         $display("FAIL map_bad_silent tone_on=%b played=%0d want 0 0", tone_on, played.size());
      end
      checks++;
   endtask

   task automatic test_full();
      string s = "cdefga";
      int    n;
      played.delete();
      // Edge 1: c pushed into the empty FIFO.
      in_valid = 1'b1; in_ascii = s[0];
      tick();
      if (q_level !== 3'd1) begin
         errors++; $display("FAIL full_e1 q_level=%0d want 1", q_level);
      end
      checks++;
      // Edge 2: c is popped and d is pushed, so the level is unchanged.
      in_ascii = s[1];
      tick();
      if (q_level !== 3'd1 || tone_on !== 1'b1 || note !== 4'd0) begin
         errors++; $display("FAIL full_e2 q_level=%0d tone_on=%b note=%0d want 1 1 0", q_level, tone_on, note);
      end
      checks++;
      in_ascii = s[2]; tick();
      in_ascii = s[3]; tick();
      in_ascii = s[4]; tick();
      if (q_level !== 3'd4 || in_ready !== 1'b0) begin
         errors++; $display("FAIL full_e5 q_level=%0d in_ready=%b want 4 0", q_level, in_ready);
      end
      checks++;
      // 'a' waits with valid high: edges 6..13.
      in_ascii = s[5];
      for (int i = 6; i <= 13; i++) tick();
      if (q_level !== 3'd4 || in_ready !== 1'b0 || tone_on !== 1'b0) begin
         errors++; $display("FAIL full_e13 q_level=%0d in_ready=%b tone_on=%b want 4 0 0", q_level, in_ready, tone_on);
      end
      checks++;
      // Edge 14: the gap ends and d is popped. Ready was low, so 'a' is not taken yet.
      tick();
      if (q_level !== 3'd3 || in_ready !== 1'b1 || tone_on !== 1'b1 || note !== 4'd1) begin
         errors++;
         $display("FAIL full_e14 q_level=%0d in_ready=%b tone_on=%b note=%0d want 3 1 1 1",
                  q_level, in_ready, tone_on, note);
      end
      checks++;
      tick();
      in_valid = 1'b0;
      if (q_level !== 3'd4) begin
         errors++; $display("FAIL full_e15 q_level=%0d want 4", q_level);
      end
      checks++;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         errors++; $display("FAIL full_timeout busy=%b want 0 within 200 cycles", busy);
      end
      checks++;
      if (played.size() != 6) begin
         errors++; $display("FAIL full_count played=%0d want 6", played.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (played[i] != i) begin
               errors++; $display("FAIL full_order%0d note=%0d want %0d", i, played[i], i);
            end
         end
      end
      checks++;
   endtask

   task automatic test_stop();
      played.delete();
      in_valid = 1'b1; in_ascii = "c"; tick();
      in_ascii = "d"; tick();
      in_ascii = "e"; tick();
      in_valid = 1'b0;
      for (int i = 4; i <= 16; i++) tick();   // d sounds from edge 14
      if (tone_on !== 1'b1 || note !== 4'd1 || q_level !== 3'd1) begin
         errors++; $display("FAIL stop_pre tone_on=%b note=%0d q_level=%0d want 1 1 1", tone_on, note, q_level);
      end
      checks++;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      if (tone_on !== 1'b0 || q_level !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stop_flush tone_on=%b q_level=%0d busy=%b in_ready=%b want 0 0 0 1",
                  tone_on, q_level, busy, in_ready);
      end
      checks++;
      for (int i = 0; i < 15; i++) tick();
      if (tone_on !== 1'b0 || busy !== 1'b0 || played.size() != 2) begin
         errors++; $display("FAIL stop_quiet tone_on=%b busy=%b played=%0d want 0 0 2", tone_on, busy, played.size());
      end else if (played[0] != 0 || played[1] != 1) begin
         errors++; $display("FAIL stop_order got %0d %0d want 0 1", played[0], played[1]);
      end
      checks++;
      // A push on the same edge as stop is dropped.
      stop = 1'b1; in_valid = 1'b1; in_ascii = "g";
      tick();
      stop = 1'b0; in_valid = 1'b0;
      if (q_level !== 3'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL stop_push q_level=%0d busy=%b want 0 0", q_level, busy);
      end
      checks++;
      tick(); tick(); tick();
      if (tone_on !== 1'b0 || played.size() != 2) begin
         errors++; $display("FAIL stop_push_silent tone_on=%b played=%0d want 0 2", tone_on, played.size());
      end
      checks++;
   endtask

`ifdef NOTE_SEQ_REPEAT_EN
   task automatic test_repeat();
      int n;
      int exp_seq[6] = '{2, 0, 1, 0, 1, 0};
      played.delete();
      // 'e' starts playing at once, so c and d are still queued when repeat turns on.
      in_valid = 1'b1; in_ascii = "e"; tick();
      in_ascii = "c"; tick();
      in_ascii = "d"; tick();
      in_valid = 1'b0;
      repeat_en = 1'b1;
      #1;
      if (in_ready !== 1'b0 || q_level !== 3'd2) begin
         errors++; $display("FAIL rep_ready in_ready=%b q_level=%0d want 0 2", in_ready, q_level);
      end
      checks++;
      n = 0;
      while (played.size() < 6 && n < 120) begin tick(); n++; end
      if (played.size() < 6) begin
         errors++; $display("FAIL rep_timeout played=%0d want 6", played.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (played[i] != exp_seq[i]) begin
               errors++; $display("FAIL rep_seq%0d note=%0d want %0d", i, played[i], exp_seq[i]);
            end
         end
         if (q_level !== 3'd2) begin
            errors++; $display("FAIL rep_level q_level=%0d want 2", q_level);
         end
      end
      checks++;
      stop = 1'b1; tick(); stop = 1'b0;
      repeat_en = 1'b0;
      if (q_level !== 3'd0 || tone_on !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rep_stop q_level=%0d tone_on=%b busy=%b want 0 0 0", q_level, tone_on, busy);
      end
      checks++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_mapping();
      test_full();
      test_stop();
`ifdef NOTE_SEQ_REPEAT_EN
      test_repeat();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule
